// File: rtl/piso_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx_if
// Description : Word handshake and serial output bundle for piso_tx.
// Revision    : 1.0 - initial release
// ============================================================================
interface piso_tx_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic [WIDTH-1:0] i_data;
    logic             o_ready;
    logic             o_out;
    logic             o_out_valid;
    logic             o_done;
    logic             o_busy;

    // Producer / bench side
    modport master (
        output i_valid, i_data,
        input  o_ready, o_out, o_out_valid, o_done, o_busy
    );

    // Transmitter side
    modport slave (
        input  i_valid, i_data,
        output o_ready, o_out, o_out_valid, o_done, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx
// Description : Parallel-in serial-out transmitter, MSB first, valid/ready
//               word intake with back-to-back frames. Optional even parity
//               bit selected by macro PISO_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  wire logic i_clk,
    input  wire logic i_rstn,
    piso_tx_if.slave  bus
);

`ifdef PISO_TX_PARITY_EN
    localparam int c_frame_len = WIDTH + 1;
`else
    localparam int c_frame_len = WIDTH;
`endif
    localparam int                 c_cnt_w    = $clog2(WIDTH + 2);
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(c_frame_len - 1);
    localparam logic [c_cnt_w-1:0] c_pen_idx  = c_cnt_w'(c_frame_len - 2);
`ifdef PISO_TX_PARITY_EN
    localparam logic [c_cnt_w-1:0] c_lsb_idx  = c_cnt_w'(WIDTH - 1);
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state,     w_state_nxt;
    logic [WIDTH-1:0]   r_shreg,     w_shreg_nxt;
    logic [c_cnt_w-1:0] r_cnt,       w_cnt_nxt;
    logic               r_out,       w_out_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic               r_done,      w_done_nxt;
    logic               r_busy,      w_busy_nxt;
`ifdef PISO_TX_PARITY_EN
    logic               r_par,       w_par_nxt;
`endif

    logic w_last;
    logic w_ready;
    logic w_hs;

    // r_cnt is the index of the bit currently on o_out
    assign w_last  = (r_state == ST_SHIFT) && (r_cnt == c_last_idx);
    assign w_ready = (r_state == ST_IDLE) || w_last;
    assign w_hs    = bus.i_valid && w_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_cnt_nxt       = r_cnt;
        w_out_nxt       = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_done_nxt      = 1'b0;
        w_busy_nxt      = 1'b0;
`ifdef PISO_TX_PARITY_EN
        w_par_nxt       = r_par;
`endif
        if (w_hs) begin
            // MSB goes straight to the output register; the rest queue up
            w_state_nxt     = ST_SHIFT;
            w_shreg_nxt     = {bus.i_data[WIDTH-2:0], 1'b0};
            w_cnt_nxt       = '0;
            w_out_nxt       = bus.i_data[WIDTH-1];
            w_out_valid_nxt = 1'b1;
            w_busy_nxt      = 1'b1;
`ifdef PISO_TX_PARITY_EN
            w_par_nxt       = ^bus.i_data;
`endif
        end else if ((r_state == ST_SHIFT) && !w_last) begin
            w_cnt_nxt       = r_cnt + 1'b1;
            w_shreg_nxt     = {r_shreg[WIDTH-2:0], 1'b0};
            w_out_nxt       = r_shreg[WIDTH-1];
`ifdef PISO_TX_PARITY_EN
            if (r_cnt == c_lsb_idx) begin
                w_out_nxt   = r_par;
            end
`endif
            w_out_valid_nxt = 1'b1;
            w_busy_nxt      = 1'b1;
            w_done_nxt      = (r_cnt == c_pen_idx);
        end else begin
            w_state_nxt     = ST_IDLE;
            w_shreg_nxt     = '0;
            w_cnt_nxt       = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
`ifdef PISO_TX_PARITY_EN
            r_par       <= w_par_nxt;
`endif
        end
    end

    assign bus.o_ready     = w_ready;
    assign bus.o_out       = r_out;
    assign bus.o_out_valid = r_out_valid;
    assign bus.o_done      = r_done;
    assign bus.o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_tx
// Description : Scoreboard bench for piso_tx at WIDTH=8 and WIDTH=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {
        logic b;
        logic d;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic mon_en = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    exp_t       q8[$];
    exp_t       q2[$];
    logic [7:0] wq8[$];
    logic [8:0] rx8 = '0;

    piso_tx_if #(.WIDTH(8)) bus8 ();
    piso_tx_if #(.WIDTH(2)) bus2 ();

    piso_tx #(.WIDTH(8)) u_dut8 (.i_clk(clk), .i_rstn(rstn), .bus(bus8));
    piso_tx #(.WIDTH(2)) u_dut2 (.i_clk(clk), .i_rstn(rstn), .bus(bus2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Current cycle is checked first; a handshake seen now lands at the next edge
    always @(negedge clk) begin : mon8
        exp_t       e;
        logic [8:0] rxn;
        logic [7:0] got_w;
        if (mon_en) begin
            check("ready", bus8.o_ready, q8.size() <= 1);
            check("valid", bus8.o_out_valid, q8.size() != 0);
            check("busy", bus8.o_busy, q8.size() != 0);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                check("bit", bus8.o_out, e.b);
                check("done", bus8.o_done, e.d);
                rxn = {rx8[7:0], bus8.o_out};
                rx8 = rxn;
                if (e.d && wq8.size() != 0) begin
                    got_w = PAR ? rxn[8:1] : rxn[7:0];
                    check("rx_word", got_w, wq8.pop_front());
                end
            end else begin
                check("idle_out", bus8.o_out, 1'b0);
                check("idle_done", bus8.o_done, 1'b0);
            end
        end
        if (!rstn) begin
            q8.delete();
            wq8.delete();
        end else if (bus8.i_valid && bus8.o_ready) begin
            for (int i = 7; i >= 0; i--)
                q8.push_back('{b: bus8.i_data[i], d: (i == 0) && !PAR});
            if (PAR) q8.push_back('{b: ^bus8.i_data, d: 1'b1});
            wq8.push_back(bus8.i_data);
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e2;
        if (mon_en) begin
            check("w2_ready", bus2.o_ready, q2.size() <= 1);
            check("w2_valid", bus2.o_out_valid, q2.size() != 0);
            if (q2.size() != 0) begin
                e2 = q2.pop_front();
                check("w2_bit", bus2.o_out, e2.b);
                check("w2_done", bus2.o_done, e2.d);
            end else begin
                check("w2_idle_out", bus2.o_out, 1'b0);
            end
        end
        if (!rstn) begin
            q2.delete();
        end else if (bus2.i_valid && bus2.o_ready) begin
            for (int i = 1; i >= 0; i--)
                q2.push_back('{b: bus2.i_data[i], d: (i == 0) && !PAR});
            if (PAR) q2.push_back('{b: ^bus2.i_data, d: 1'b1});
        end
    end

    task automatic send8(input logic [7:0] w);
        int   n = 0;
        logic rdy;
        bus8.i_valid = 1'b1;
        bus8.i_data  = w;
        do begin
            @(negedge clk);
            rdy = bus8.o_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 40);
        check("hs8_accept", rdy, 1'b1);
    endtask

    task automatic send2(input logic [1:0] w);
        int   n = 0;
        logic rdy;
        bus2.i_valid = 1'b1;
        bus2.i_data  = w;
        do begin
            @(negedge clk);
            rdy = bus2.o_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 40);
        check("hs2_accept", rdy, 1'b1);
    endtask

    task automatic idle(input int n);
        bus8.i_valid = 1'b0;
        bus8.i_data  = 8'($urandom);
        bus2.i_valid = 1'b0;
        bus2.i_data  = 2'($urandom);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus8.i_valid = 1'b0;
        bus8.i_data  = '0;
        bus2.i_valid = 1'b0;
        bus2.i_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        rstn   = 1'b1;
        idle(2);

        send8(8'hA5);
        idle(12);

        send8(8'hFF);
        send8(8'h00);
        idle(12);

        // Second word held pending while the first frame is still shifting
        send8(8'h96);
        bus8.i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send8(8'h3C);
        idle(12);

        send8(8'hC3);
        bus8.i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);
        send8(8'h81);
        idle(12);

        send8(8'h07);
        send8(8'h03);
        idle(12);

        for (int k = 0; k < 6; k++) begin
            send8(8'($urandom));
            if (k % 2 == 1) idle($urandom_range(1, 3));
        end
        idle(12);

        send2(2'b10);
        send2(2'b01);
        idle(3);
        send2(2'b11);
        idle(8);

        check("drain8", q8.size(), 0);
        check("drain2", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter: the sending end of the single-bit serial link whose receiver is a serial-in, parallel-out shift register. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first, one bit per clock, with a qualifying valid strobe and an end-of-frame pulse. It sits between a word-oriented producer (register file, FIFO) and the serial input of the receiving shift register.

## Interface

- WIDTH, 8, data word width in bits; legal range 2..32.
- i_clk  input  1  clock; all logic on the rising edge.
- i_rstn  input  1  reset, synchronous, active-low.
- i_valid  input  1  producer has a word on i_data.
- i_data  input  WIDTH  word to transmit; sampled only on handshake.
- o_ready  output  1  block can accept a word this cycle.
- o_out  output  1  serial data bit.
- o_out_valid  output  1  o_out carries a frame bit this cycle.
- o_done  output  1  one-cycle pulse coincident with the final bit of a frame.
- o_busy  output  1  frame in progress.

## Operation

- States: IDLE, SHIFT. Registered WIDTH-bit shift register, bit counter of width $clog2(WIDTH+2), frame length L = WIDTH (WIDTH+1 with parity).
- Handshake: transfer occurs on any rising edge where i_valid && o_ready. i_data is captured only then; it is ignored at all other times.
- o_ready = 1 in IDLE, and in SHIFT only during the final bit cycle of the frame (back-to-back support). 0 otherwise.
- IDLE -> SHIFT on handshake. Shift register loads i_data, counter loads 0.
- SHIFT: each edge drives the next bit and increments the counter. Bits go out MSB first: i_data[WIDTH-1] first, i_data[0] last (then parity, if enabled).
- Final bit cycle: if handshake, reload and stay in SHIFT (no gap); else SHIFT -> IDLE.
- o_out_valid = 1 exactly on cycles carrying frame bits. o_busy = 1 whenever o_out_valid = 1.
- Outside a frame: o_out = 0, o_out_valid = 0, o_done = 0.
- Reset values, forced at the first rising edge with i_rstn = 0: state IDLE, shift register 0, counter 0, o_out 0, o_out_valid 0, o_done 0, o_busy 0. o_ready = 1 from the first cycle after reset.
- Reset mid-frame aborts the frame with no o_done. The remaining bits are discarded and the next cycle shows idle outputs.
- i_valid held high with o_ready = 0 is not an error. The word stays pending until o_ready rises.

## Timing

- Handshake at edge N: the first bit (MSB) is on o_out with o_out_valid = 1 during cycle N+1, i.e. after edge N.
- Bit k (0 = MSB) appears in cycle N+1+k. The last bit appears in cycle N+L, with o_done = 1 and o_ready = 1 in that cycle.
- Handshake at the edge ending cycle N+L starts the next frame's MSB in cycle N+L+1. o_out_valid stays continuously high.
- No handshake at that edge: cycle N+L+1 returns to IDLE with o_out = 0, o_out_valid = 0, o_busy = 0.
- Latency from handshake to first bit: 1 cycle. Frame throughput: one word per L cycles.
- All outputs except o_ready are registered. o_ready is a decode of state and counter with no combinational path from i_valid.

## Configuration

- PISO_TX_PARITY_EN defined: one even-parity bit (XOR of all WIDTH data bits) is appended after the LSB. L = WIDTH+1, and o_done coincides with the parity bit.
- PISO_TX_PARITY_EN undefined: no parity bit, L = WIDTH. The parity logic is absent.

## Test plan

- Reset then single word: i_data = 8'hA5 handshake at edge N. o_out sequence in cycles N+1..N+8 is 1,0,1,0,0,1,0,1. o_done only in N+8. Idle in N+9. A receiver shift register captures 8'hA5.
- Back-to-back: 8'hFF then 8'h00 with i_valid held high. 16 contiguous o_out_valid cycles with bits 8×1 then 8×0. o_ready high only at start and in cycles N+8 and N+16. o_done in N+8 and N+16.
- Backpressure: i_valid high with 8'h3C while busy with a prior frame. Word accepted only at the final-bit edge, with no data corruption of either frame.
- Reset mid-frame: i_rstn = 0 during bit 3 of 8'hC3. Next cycle all outputs at reset values and no o_done. A following 8'h81 transmits cleanly.
- Parity (PISO_TX_PARITY_EN): 8'h07 gives 9 bits 0,0,0,0,0,1,1,1,1 with o_done on the 9th bit. 8'h03 gives parity bit 0.
- WIDTH = 2 edge case: 2'b10 gives bits 1,0, o_done in cycle N+2, and back-to-back reload works at that boundary.
